// File: rtl/rob_commit.sv
// rob_commit: reorder buffer, one alloc and two completions per cycle, in-order retire to the register file.
// Optional second retire slot enabled by ROB_DUAL_COMMIT_EN.
module rob_commit #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4,
  parameter int PR_SIZE = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               alloc_valid,
  input  logic [PR_SIZE-1:0] alloc_dest,
  input  logic [PR_SIZE-1:0] alloc_old,
  output logic               alloc_ready,
  output logic [TAG_W-1:0]   alloc_tag,
  input  logic               cmpl_valid1,
  input  logic [TAG_W-1:0]   cmpl_tag1,
  input  logic [31:0]        cmpl_data1,
  input  logic               cmpl_valid2,
  input  logic [TAG_W-1:0]   cmpl_tag2,
  input  logic [31:0]        cmpl_data2,
  output logic               write_en,
  output logic [PR_SIZE-1:0] write_addr1,
  output logic [31:0]        write_data1,
  output logic [PR_SIZE-1:0] old_addr1,
  output logic [PR_SIZE-1:0] write_addr2,
  output logic [31:0]        write_data2,
  output logic [PR_SIZE-1:0] old_addr2,
  output logic [TAG_W:0]     count
);
  localparam int CW = TAG_W + 1;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  logic [PR_SIZE-1:0] dest_q [DEPTH];
  logic [PR_SIZE-1:0] dest_d [DEPTH];
  logic [PR_SIZE-1:0] old_q [DEPTH];
  logic [PR_SIZE-1:0] old_d [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, head1;
  logic [CW-1:0] count_q, count_d;
  logic write_en_q, write_en_d;
  logic [PR_SIZE-1:0] write_addr1_q, write_addr1_d, write_addr2_q, write_addr2_d;
  logic [PR_SIZE-1:0] old_addr1_q, old_addr1_d, old_addr2_q, old_addr2_d;
  logic [31:0] write_data1_q, write_data1_d, write_data2_q, write_data2_d;
  logic alloc, c1, c2, r1, r2;
  assign head1 = head_q + TAG_W'(1);
  assign alloc_ready = count_q != CW'(DEPTH);
  assign alloc_tag = tail_q;
  assign alloc = alloc_valid & alloc_ready;
  // Completion state is registered, so a retiring entry can never also be completing.
  assign c1 = cmpl_valid1 & valid_q[cmpl_tag1] & ~done_q[cmpl_tag1];
  assign c2 = cmpl_valid2 & valid_q[cmpl_tag2] & ~done_q[cmpl_tag2] & ~(cmpl_valid1 && cmpl_tag1 == cmpl_tag2);
  assign r1 = valid_q[head_q] & done_q[head_q] & ~flush;
`ifdef ROB_DUAL_COMMIT_EN
  assign r2 = r1 & valid_q[head1] & done_q[head1];
`else
  assign r2 = 1'b0;
`endif
  always_comb begin
    valid_d = valid_q;
    done_d = done_q;
    dest_d = dest_q;
    old_d = old_q;
    data_d = data_q;
    if (c1) begin
      done_d[cmpl_tag1] = 1'b1;
      data_d[cmpl_tag1] = cmpl_data1;
    end
    if (c2) begin
      done_d[cmpl_tag2] = 1'b1;
      data_d[cmpl_tag2] = cmpl_data2;
    end
    if (r1) valid_d[head_q] = 1'b0;
    if (r2) valid_d[head1] = 1'b0;
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      dest_d[tail_q] = alloc_dest;
      old_d[tail_q] = alloc_old;
    end
    head_d = head_q + TAG_W'(r1) + TAG_W'(r2);
    tail_d = tail_q + TAG_W'(alloc);
    count_d = count_q + CW'(alloc) - CW'(r1) - CW'(r2);
    if (flush) begin
      valid_d = '0;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end
    write_en_d = r1;
    write_addr1_d = r1 ? dest_q[head_q] : '0;
    write_data1_d = r1 ? data_q[head_q] : '0;
    old_addr1_d = r1 ? old_q[head_q] : '0;
    write_addr2_d = r2 ? dest_q[head1] : '0;
    write_data2_d = r2 ? data_q[head1] : '0;
    old_addr2_d = r2 ? old_q[head1] : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= '0;
      done_q <= '0;
      dest_q <= '{default: '0};
      old_q <= '{default: '0};
      data_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      write_en_q <= 1'b0;
      write_addr1_q <= '0;
      write_data1_q <= '0;
      old_addr1_q <= '0;
      write_addr2_q <= '0;
      write_data2_q <= '0;
      old_addr2_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q <= done_d;
      dest_q <= dest_d;
      old_q <= old_d;
      data_q <= data_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      write_en_q <= write_en_d;
      write_addr1_q <= write_addr1_d;
      write_data1_q <= write_data1_d;
      old_addr1_q <= old_addr1_d;
      write_addr2_q <= write_addr2_d;
      write_data2_q <= write_data2_d;
      old_addr2_q <= old_addr2_d;
    end
  assign count = count_q;
  assign write_en = write_en_q;
  assign write_addr1 = write_addr1_q;
  assign write_data1 = write_data1_q;
  assign old_addr1 = old_addr1_q;
  assign write_addr2 = write_addr2_q;
  assign write_data2 = write_data2_q;
  assign old_addr2 = old_addr2_q;
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed and random checks of rob_commit against a queue-based program-order model.
module tb_rob_commit;
`ifdef ROB_DUAL_COMMIT_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  logic clk = 0, rst = 1, flush = 0, alloc_valid = 0, cmpl_valid1 = 0, cmpl_valid2 = 0;
  logic [5:0] alloc_dest = 0, alloc_old = 0;
  logic [3:0] cmpl_tag1 = 0, cmpl_tag2 = 0;
  logic [31:0] cmpl_data1 = 0, cmpl_data2 = 0;
  logic alloc_ready, write_en;
  logic [3:0] alloc_tag;
  logic [5:0] write_addr1, write_addr2, old_addr1, old_addr2;
  logic [31:0] write_data1, write_data2;
  logic [4:0] count;
  int nvec = 0, nerr = 0;

  rob_commit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_old(alloc_old),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cmpl_valid1(cmpl_valid1), .cmpl_tag1(cmpl_tag1), .cmpl_data1(cmpl_data1),
    .cmpl_valid2(cmpl_valid2), .cmpl_tag2(cmpl_tag2), .cmpl_data2(cmpl_data2),
    .write_en(write_en), .write_addr1(write_addr1), .write_data1(write_data1), .old_addr1(old_addr1),
    .write_addr2(write_addr2), .write_data2(write_data2), .old_addr2(old_addr2), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [5:0]  dest;
    logic [5:0]  old;
    bit          done;
    logic [31:0] data;
  } ent_t;
  ent_t mq[$];
  int m_tail;
  logic e_we;
  logic [5:0] e_a1, e_o1, e_a2, e_o2;
  logic [31:0] e_d1, e_d2;

  task automatic clear_exp();
    e_we = 0; e_a1 = 0; e_d1 = 0; e_o1 = 0; e_a2 = 0; e_d2 = 0; e_o2 = 0;
  endtask

  task automatic m_complete(input logic v, input logic [3:0] t, input logic [31:0] d);
    foreach (mq[i])
      if (v && mq[i].tag == t && !mq[i].done) begin
        mq[i].done = 1;
        mq[i].data = d;
      end
  endtask

  // Program-order model: the queue front is the oldest in-flight instruction.
  task automatic model_step();
    int n;
    bit rdy;
    clear_exp();
    if (flush) begin
      mq.delete();
      m_tail = 0;
      return;
    end
    rdy = mq.size() != 16;
    n = 0;
    if (mq.size() > 0 && mq[0].done) n = 1;
    if (DUAL && n == 1 && mq.size() > 1 && mq[1].done) n = 2;
    if (n >= 1) begin e_we = 1; e_a1 = mq[0].dest; e_d1 = mq[0].data; e_o1 = mq[0].old; end
    if (n == 2) begin e_a2 = mq[1].dest; e_d2 = mq[1].data; e_o2 = mq[1].old; end
    m_complete(cmpl_valid1, cmpl_tag1, cmpl_data1);
    m_complete(cmpl_valid2, cmpl_tag2, cmpl_data2);
    repeat (n) void'(mq.pop_front());
    if (alloc_valid && rdy) begin
      mq.push_back('{4'(m_tail), alloc_dest, alloc_old, 1'b0, 32'h0});
      m_tail = (m_tail + 1) % 16;
    end
  endtask

  task automatic idle();
    flush = 0; alloc_valid = 0; cmpl_valid1 = 0; cmpl_valid2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    mq.delete();
    m_tail = 0;
    clear_exp();
  endtask

  task automatic alloc_one(input logic [5:0] d, input logic [5:0] o);
    alloc_valid = 1; alloc_dest = d; alloc_old = o;
    tick();
    alloc_valid = 0;
  endtask

  function automatic logic [3:0] pick_tag();
    if (mq.size() > 0 && $urandom_range(3) != 0) return mq[$urandom_range(mq.size() - 1)].tag;
    return 4'($urandom);
  endfunction

  task automatic test_reset();
    idle();
    rst = 1;
    #3;
    nvec++;
    if (write_en !== 0 || count !== 0 || alloc_ready !== 1 || alloc_tag !== 0 || write_addr1 !== 0) begin
      nerr++;
      $display("FAIL reset_hold: we=%0b cnt=%0d rdy=%0b tag=%0d a1=%0d, expected 0 0 1 0 0", write_en, count, alloc_ready, alloc_tag, write_addr1);
    end
    @(posedge clk); #1;
    rst = 0; mq.delete(); m_tail = 0; clear_exp();
    repeat (10) begin
      tick();
      nvec++;
      if (write_en !== 0 || count !== 0 || alloc_ready !== 1 || alloc_tag !== 0) begin
        nerr++;
        $display("FAIL reset_idle: we=%0b cnt=%0d rdy=%0b tag=%0d, expected 0 0 1 0", write_en, count, alloc_ready, alloc_tag);
      end
    end
    alloc_one(6'd9, 6'd1); alloc_one(6'd10, 6'd2); alloc_one(6'd11, 6'd3);
    cmpl_valid1 = 1; cmpl_tag1 = 0; cmpl_data1 = 32'hABCD;
    tick(); idle();
    tick();
    nvec++;
    if (write_en !== 1 || write_addr1 !== 9 || write_data1 !== 32'hABCD) begin
      nerr++;
      $display("FAIL pre_async_retire: we=%0b a1=%0d d1=%0h, expected 1 9 abcd", write_en, write_addr1, write_data1);
    end
    #2 rst = 1;
    #1;
    nvec++;
    if (write_en !== 0 || count !== 0 || alloc_ready !== 1 || alloc_tag !== 0 || write_addr1 !== 0 || write_data1 !== 0 || old_addr1 !== 0) begin
      nerr++;
      $display("FAIL reset_async: we=%0b cnt=%0d rdy=%0b tag=%0d a1=%0d d1=%0h o1=%0d, expected all 0 except rdy=1",
               write_en, count, alloc_ready, alloc_tag, write_addr1, write_data1, old_addr1);
    end
    @(posedge clk); #1;
    rst = 0; mq.delete(); m_tail = 0; clear_exp();
  endtask

  task automatic test_pair_retire();
    do_reset();
    alloc_one(6'd5, 6'd2); alloc_one(6'd6, 6'd3);
    nvec++;
    if (count !== 2 || alloc_tag !== 2) begin
      nerr++; $display("FAIL pair_alloc: cnt=%0d tag=%0d, expected 2 2", count, alloc_tag);
    end
    cmpl_valid1 = 1; cmpl_tag1 = 0; cmpl_data1 = 11;
    cmpl_valid2 = 1; cmpl_tag2 = 1; cmpl_data2 = 22;
    tick(); idle();
    nvec++;
    if (write_en !== 0) begin
      nerr++; $display("FAIL pair_early: we=%0b, expected 0", write_en);
    end
    tick();
    nvec++;
    if (write_en !== 1 || write_addr1 !== 5 || write_data1 !== 11 || old_addr1 !== 2 ||
        write_addr2 !== e_a2 || write_data2 !== e_d2 || old_addr2 !== e_o2 || count !== 5'(mq.size())) begin
      nerr++;
      $display("FAIL pair_retire: we=%0b a1=%0d d1=%0d o1=%0d a2=%0d d2=%0d o2=%0d cnt=%0d, expected 1 5 11 2 %0d %0d %0d %0d",
               write_en, write_addr1, write_data1, old_addr1, write_addr2, write_data2, old_addr2, count, e_a2, e_d2, e_o2, mq.size());
    end
    tick();
    nvec++;
    if (write_en !== e_we || write_addr1 !== e_a1 || write_data1 !== e_d1 || old_addr1 !== e_o1 || write_addr2 !== 0 || count !== 0) begin
      nerr++;
      $display("FAIL pair_second: we=%0b a1=%0d d1=%0d o1=%0d a2=%0d cnt=%0d, expected %0b %0d %0d %0d 0 0",
               write_en, write_addr1, write_data1, old_addr1, write_addr2, count, e_we, e_a1, e_d1, e_o1);
    end
    tick();
    nvec++;
    if (write_en !== 0 || write_addr1 !== 0 || write_data1 !== 0) begin
      nerr++; $display("FAIL pair_drop: we=%0b a1=%0d d1=%0d, expected 0 0 0", write_en, write_addr1, write_data1);
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    alloc_one(6'd7, 6'd1); alloc_one(6'd8, 6'd4);
    cmpl_valid1 = 1; cmpl_tag1 = 1; cmpl_data1 = 99;
    tick(); idle();
    repeat (2) begin
      tick();
      nvec++;
      if (write_en !== 0 || count !== 2) begin
        nerr++; $display("FAIL ooo_blocked: we=%0b cnt=%0d, expected 0 2", write_en, count);
      end
    end
    cmpl_valid2 = 1; cmpl_tag2 = 0; cmpl_data2 = 7;
    tick(); idle();
    tick();
    nvec++;
    if (write_en !== 1 || write_addr1 !== 7 || write_data1 !== 7 || old_addr1 !== 1 ||
        write_addr2 !== e_a2 || write_data2 !== e_d2 || old_addr2 !== e_o2) begin
      nerr++;
      $display("FAIL ooo_retire: we=%0b a1=%0d d1=%0d o1=%0d a2=%0d d2=%0d o2=%0d, expected 1 7 7 1 %0d %0d %0d",
               write_en, write_addr1, write_data1, old_addr1, write_addr2, write_data2, old_addr2, e_a2, e_d2, e_o2);
    end
    tick();
    nvec++;
    if (write_en !== e_we || write_addr1 !== e_a1 || write_data1 !== e_d1 || count !== 0) begin
      nerr++;
      $display("FAIL ooo_tail: we=%0b a1=%0d d1=%0d cnt=%0d, expected %0b %0d %0d 0", write_en, write_addr1, write_data1, count, e_we, e_a1, e_d1);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) alloc_one(6'(i + 1), 6'(i));
    nvec++;
    if (alloc_ready !== 0 || count !== 16 || alloc_tag !== 0) begin
      nerr++; $display("FAIL full: rdy=%0b cnt=%0d tag=%0d, expected 0 16 0", alloc_ready, count, alloc_tag);
    end
    cmpl_valid1 = 1; cmpl_tag1 = 0; cmpl_data1 = 32'hF00D;
    alloc_valid = 1; alloc_dest = 6'd40; alloc_old = 6'd41;
    tick();
    cmpl_valid1 = 0;
    nvec++;
    if (count !== 16 || alloc_ready !== 0 || write_en !== 0) begin
      nerr++; $display("FAIL full_refuse: cnt=%0d rdy=%0b we=%0b, expected 16 0 0", count, alloc_ready, write_en);
    end
    tick();
    nvec++;
    if (write_en !== 1 || write_addr1 !== 1 || write_data1 !== 32'hF00D || count !== 15 || alloc_ready !== 1 || alloc_tag !== 0) begin
      nerr++;
      $display("FAIL full_retire: we=%0b a1=%0d d1=%0h cnt=%0d rdy=%0b tag=%0d, expected 1 1 f00d 15 1 0",
               write_en, write_addr1, write_data1, count, alloc_ready, alloc_tag);
    end
    tick();
    alloc_valid = 0;
    nvec++;
    if (count !== 16 || alloc_tag !== 1 || write_en !== 0 || alloc_ready !== 0) begin
      nerr++; $display("FAIL full_wrap: cnt=%0d tag=%0d we=%0b rdy=%0b, expected 16 1 0 0", count, alloc_tag, write_en, alloc_ready);
    end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_one(6'd9, 6'd1); alloc_one(6'd10, 6'd2); alloc_one(6'd11, 6'd3);
    cmpl_valid1 = 1; cmpl_tag1 = 0; cmpl_data1 = 5;
    cmpl_valid2 = 1; cmpl_tag2 = 1; cmpl_data2 = 6;
    tick(); idle();
    flush = 1;
    tick();
    flush = 0;
    nvec++;
    if (write_en !== 0 || count !== 0 || alloc_tag !== 0 || alloc_ready !== 1) begin
      nerr++; $display("FAIL flush: we=%0b cnt=%0d tag=%0d rdy=%0b, expected 0 0 0 1", write_en, count, alloc_tag, alloc_ready);
    end
    cmpl_valid1 = 1; cmpl_tag1 = 2; cmpl_data1 = 77;
    tick(); idle();
    repeat (2) begin
      tick();
      nvec++;
      if (write_en !== 0 || count !== 0) begin
        nerr++; $display("FAIL flush_late: we=%0b cnt=%0d, expected 0 0", write_en, count);
      end
    end
    alloc_one(6'd12, 6'd13);
    nvec++;
    if (count !== 1 || alloc_tag !== 1) begin
      nerr++; $display("FAIL flush_realloc: cnt=%0d tag=%0d, expected 1 1", count, alloc_tag);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      alloc_valid = $urandom_range(9) < (((c / 400) % 2) != 0 ? 9 : 4);
      alloc_dest = 6'($urandom); alloc_old = 6'($urandom);
      cmpl_valid1 = $urandom_range(2) == 0; cmpl_tag1 = pick_tag(); cmpl_data1 = $urandom;
      cmpl_valid2 = $urandom_range(2) == 0; cmpl_tag2 = pick_tag(); cmpl_data2 = $urandom;
      if ($urandom_range(7) == 0) cmpl_tag2 = cmpl_tag1;
      flush = $urandom_range(149) == 0;
      tick();
      nvec++;
      if ({write_en, write_addr1, write_data1, old_addr1, write_addr2, write_data2, old_addr2} !==
          {e_we, e_a1, e_d1, e_o1, e_a2, e_d2, e_o2} ||
          count !== 5'(mq.size()) || alloc_ready !== (mq.size() != 16) || alloc_tag !== 4'(m_tail)) begin
        nerr++;
        $display("FAIL random c=%0d: got we=%0b a1=%0d d1=%0h o1=%0d a2=%0d d2=%0h o2=%0d cnt=%0d rdy=%0b tag=%0d; expected %0b %0d %0h %0d %0d %0h %0d %0d %0b %0d",
                 c, write_en, write_addr1, write_data1, old_addr1, write_addr2, write_data2, old_addr2, count, alloc_ready, alloc_tag,
                 e_we, e_a1, e_d1, e_o1, e_a2, e_d2, e_o2, mq.size(), mq.size() != 16, m_tail);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_pair_retire();
    test_out_of_order();
    test_full();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
